// File: rtl/disp_pkg.sv
// Shared display package: active-low seven-segment glyphs for hex digits 0-F,
// the all-dark segment pattern, slot FSM state encodings and a glyph lookup.
package disp_pkg;

    // Active-low {g,f,e,d,c,b,a} glyphs, decimal point excluded.
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    // Every segment and the decimal point dark.
    localparam logic [7:0] SSEG_OFF = 8'hFF;

    // Per-slot phase: DEAD keeps all anodes high, ON lets PWM drive the anode.
    typedef enum logic {
        DEAD = 1'b0,
        ON   = 1'b1
    } slot_state_t;

    function automatic logic [6:0] hex_glyph(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/disp_hex_mux_n_if.sv
// Bundle between the datapath (master: digit values, brightness, dead time)
// and the display driver (slave: drives anodes, segments and the slot tick).
interface disp_hex_mux_n_if #(
    parameter int N_DIGITS = 4,
    parameter int PWM_BITS = 4,
    parameter int DT_BITS  = 8
);
    logic [4*N_DIGITS-1:0] hex_in;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   blank_in;
    logic [PWM_BITS-1:0]   bright;
    logic [DT_BITS-1:0]    dead_time;
    logic [N_DIGITS-1:0]   an;
    logic [7:0]            sseg;
    logic                  digit_tick;

    modport master (
        output hex_in, dp_in, blank_in, bright, dead_time,
        input  an, sseg, digit_tick
    );

    modport slave (
        input  hex_in, dp_in, blank_in, bright, dead_time,
        output an, sseg, digit_tick
    );
endinterface

// File: rtl/hex_to_sseg.sv
// Combinational nibble + decimal point to active-low {dp,g,f,e,d,c,b,a}.
module hex_to_sseg
    import disp_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    output logic [7:0] sseg
);

    // Glyph lookup with the decimal point inverted for the active-low pin.
    always_comb begin
        sseg = {~dp, hex_glyph(hex)};
    end

endmodule

// File: rtl/disp_hex_mux_n.sv
// Time-multiplexed N-digit seven-segment driver with per-slot brightness PWM,
// programmable anode dead time and optional leading-zero blanking
// (enabled by defining DISP_LEAD_ZERO_BLANK_EN).
// Each slot lasts 2^SLOT_BITS cycles; all per-digit inputs are sampled once
// at slot start (s==0) so mid-slot input changes never tear the display.
// Outputs are registered, so the value decided while s==k is seen at s==k+1.
module disp_hex_mux_n
    import disp_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int SLOT_BITS = 16,
    parameter int PWM_BITS  = 4,
    parameter int DT_BITS   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    disp_hex_mux_n_if.slave  bus
);

    localparam int D_W = $clog2(N_DIGITS);

    logic [SLOT_BITS-1:0] s_reg;
    logic [D_W-1:0]       d_reg;
    slot_state_t          state_reg;
    logic [N_DIGITS-1:0]  an_reg;
    logic [7:0]           sseg_reg;
    logic                 digit_tick_reg;
    logic [PWM_BITS-1:0]  bright_snap;
    logic [DT_BITS-1:0]   dead_snap;
    logic                 blank_snap;

    logic [3:0]           nib [N_DIGITS];
    logic [N_DIGITS-1:0]  lz_blank;
    logic [N_DIGITS-1:0]  digit_sel;
    logic [3:0]           nib_sel;
    logic                 dp_sel;
    logic                 blank_now;
    logic [7:0]           glyph_now;
    logic                 s_max;
    logic                 s_zero;
    logic [PWM_BITS-1:0]  bright_eff;
    logic [DT_BITS-1:0]   dead_eff;
    logic                 blank_eff;
    logic                 past_dead;
    logic                 pwm_on;
    logic [N_DIGITS-1:0]  an_lit;

    // Split the packed digit bus and build the one-hot digit select.
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
        assign nib[gi]       = bus.hex_in[4*gi +: 4];
        assign digit_sel[gi] = (d_reg == D_W'(gi));
    end

`ifdef DISP_LEAD_ZERO_BLANK_EN
    // A digit above the rightmost one goes dark when it and every digit
    // to its left are zero; the rightmost digit always shows.
    logic [N_DIGITS-1:0] upper_zero;
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_lz
        assign upper_zero[gi] = (bus.hex_in[4*N_DIGITS-1:4*gi] == '0);
        if (gi == 0) begin : g_first
            assign lz_blank[gi] = 1'b0;
        end else begin : g_upper
            assign lz_blank[gi] = upper_zero[gi];
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign nib_sel   = nib[d_reg];
    assign dp_sel    = bus.dp_in[d_reg];
    assign blank_now = bus.blank_in[d_reg] | lz_blank[d_reg];

    hex_to_sseg u_hex_to_sseg (
        .hex  (nib_sel),
        .dp   (dp_sel),
        .sseg (glyph_now)
    );

    // At s==0 the snapshot registers are still being loaded, so decisions
    // taken in that cycle use the live inputs that are being captured.
    assign s_max      = &s_reg;
    assign s_zero     = (s_reg == '0);
    assign bright_eff = s_zero ? bus.bright    : bright_snap;
    assign dead_eff   = s_zero ? bus.dead_time : dead_snap;
    assign blank_eff  = s_zero ? blank_now     : blank_snap;
    assign past_dead  = (s_reg >= SLOT_BITS'(dead_eff));
    assign pwm_on     = (s_reg[PWM_BITS-1:0] < bright_eff);
    assign an_lit     = (pwm_on && !blank_eff) ? ~digit_sel : '1;

    // Counters, snapshot registers and the DEAD/ON slot FSM with registered
    // anode/segment outputs; the wrap cycle always forces a dark s==0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_reg          <= '0;
            d_reg          <= '0;
            state_reg      <= DEAD;
            an_reg         <= '1;
            sseg_reg       <= SSEG_OFF;
            digit_tick_reg <= 1'b0;
            bright_snap    <= '0;
            dead_snap      <= '0;
            blank_snap     <= 1'b1;
        end else begin
            s_reg          <= s_reg + 1'b1;
            digit_tick_reg <= s_max;
            if (s_max) begin
                d_reg <= (d_reg == D_W'(N_DIGITS - 1)) ? '0 : d_reg + 1'b1;
            end

            if (s_zero) begin
                bright_snap <= bus.bright;
                dead_snap   <= bus.dead_time;
                blank_snap  <= blank_now;
                sseg_reg    <= blank_now ? SSEG_OFF : glyph_now;
            end

            case (state_reg)
                DEAD: begin
                    if (!s_max && past_dead) begin
                        state_reg <= ON;
                        an_reg    <= an_lit;
                    end else begin
                        an_reg    <= '1;
                    end
                end
                ON: begin
                    if (s_max) begin
                        state_reg <= DEAD;
                        an_reg    <= '1;
                    end else begin
                        an_reg    <= an_lit;
                    end
                end
                default: begin
                    state_reg <= DEAD;
                    an_reg    <= '1;
                end
            endcase
        end
    end

    assign bus.an         = an_reg;
    assign bus.sseg       = sseg_reg;
    assign bus.digit_tick = digit_tick_reg;

endmodule
